// File: rtl/fetch_sequencer.sv
// PC sequencer and prefetch buffer between instruction memory and decode.
// Credit-based request issue, in-order response tagging, redirect flush with stale-response drop.
module fetch_sequencer #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            fetch_idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
  logic [31:0]     instr_mem [FIFO_DEPTH];

  logic            req_fire;
  logic            rsp;
  logic            pop;
  logic            push;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_target;

  assign credit_used     = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid  = reset_n && (credit_used < {1'b0, DEPTH_C}) && (inflight < DEPTH_C);
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign rsp             = imem_rsp_valid;
  assign pop             = id_valid && id_ready;
  assign push            = rsp && (drop_cnt == '0) && !redirect_valid;
  assign redirect_target = redirect_pc & ~XLEN'(3);

  assign id_valid   = (count != '0);
  assign id_instr   = instr_mem[rd_ptr];
  assign id_pc      = pc_mem[rd_ptr];
  assign fetch_idle = (inflight == '0) && (count == '0);

  // Outstanding requests after this edge; on redirect all of them become stale.
  always_comb begin
    inflight_nxt = inflight;
    if (req_fire && !rsp)
      inflight_nxt = inflight + CW'(1);
    else if (!req_fire && rsp)
      inflight_nxt = inflight - CW'(1);
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (!push && pop)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        drop_cnt <= inflight_nxt;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + PC_STEP;
        if (rsp && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + PC_STEP;
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]    <= RESET_PC;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
  end

  a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (!reset_n)
    rsp |-> (inflight != '0));
  a_drop_le_inflight: assert property (@(posedge clk) disable iff (!reset_n)
    drop_cnt <= inflight);
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (count == DEPTH_C)));
  a_addr_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (imem_req_valid && !imem_req_ready && !redirect_valid) |=> $stable(imem_req_addr));

endmodule
